// File: rtl/vga_resolution_demonstrator.sv
// VGA timing generator with an 8-bar colour test pattern, 640x480 or 800x600 chosen per frame.
// Optional build macro VGA_BORDER_EN draws a one-pixel white frame around the active area.
module vga_resolution_demonstrator #(
    parameter int H0_ACT  = 640,
    parameter int H0_FP   = 16,
    parameter int H0_SYNC = 96,
    parameter int H0_BP   = 48,
    parameter int V0_ACT  = 480,
    parameter int V0_FP   = 10,
    parameter int V0_SYNC = 2,
    parameter int V0_BP   = 33,
    parameter int H1_ACT  = 800,
    parameter int H1_FP   = 24,
    parameter int H1_SYNC = 72,
    parameter int H1_BP   = 128,
    parameter int V1_ACT  = 600,
    parameter int V1_FP   = 1,
    parameter int V1_SYNC = 2,
    parameter int V1_BP   = 22
) (
    input  logic       CLOCK_25,
    input  logic       reset,
    input  logic       choose_vga_mode,
    output logic [2:0] VGA_RED,
    output logic [2:0] VGA_GREEN,
    output logic [2:0] VGA_BLUE,
    output logic       HS,
    output logic       VS
);

    localparam logic [10:0] H0_A   = 11'(H0_ACT);
    localparam logic [10:0] H0_SS  = 11'(H0_ACT + H0_FP);
    localparam logic [10:0] H0_SE  = 11'(H0_ACT + H0_FP + H0_SYNC);
    localparam logic [10:0] H0_TOT = 11'(H0_ACT + H0_FP + H0_SYNC + H0_BP);
    localparam logic [9:0]  V0_A   = 10'(V0_ACT);
    localparam logic [9:0]  V0_SS  = 10'(V0_ACT + V0_FP);
    localparam logic [9:0]  V0_SE  = 10'(V0_ACT + V0_FP + V0_SYNC);
    localparam logic [9:0]  V0_TOT = 10'(V0_ACT + V0_FP + V0_SYNC + V0_BP);
    localparam logic [10:0] H1_A   = 11'(H1_ACT);
    localparam logic [10:0] H1_SS  = 11'(H1_ACT + H1_FP);
    localparam logic [10:0] H1_SE  = 11'(H1_ACT + H1_FP + H1_SYNC);
    localparam logic [10:0] H1_TOT = 11'(H1_ACT + H1_FP + H1_SYNC + H1_BP);
    localparam logic [9:0]  V1_A   = 10'(V1_ACT);
    localparam logic [9:0]  V1_SS  = 10'(V1_ACT + V1_FP);
    localparam logic [9:0]  V1_SE  = 10'(V1_ACT + V1_FP + V1_SYNC);
    localparam logic [9:0]  V1_TOT = 10'(V1_ACT + V1_FP + V1_SYNC + V1_BP);
    localparam int          H0_BW  = H0_ACT / 8;
    localparam int          H1_BW  = H1_ACT / 8;

    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        mode_q, mode_d;
    logic [10:0] hcount_q, hcount_d;
    logic [9:0]  vcount_q, vcount_d;
    logic [2:0]  red_q, red_d;
    logic [2:0]  green_q, green_d;
    logic [2:0]  blue_q, blue_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;

    logic [10:0] hact, hss, hse, htot;
    logic [9:0]  vact, vss, vse, vtot;
    logic        h_last, v_last;
    logic        active;
    logic        h_sync_on, v_sync_on;
    logic [2:0]  bar;

    // Geometry of the frame currently being scanned; mode_q only moves at a frame boundary.
    always_comb begin
        hact = H0_A;
        hss  = H0_SS;
        hse  = H0_SE;
        htot = H0_TOT;
        vact = V0_A;
        vss  = V0_SS;
        vse  = V0_SE;
        vtot = V0_TOT;
        if (mode_q) begin
            hact = H1_A;
            hss  = H1_SS;
            hse  = H1_SE;
            htot = H1_TOT;
            vact = V1_A;
            vss  = V1_SS;
            vse  = V1_SE;
            vtot = V1_TOT;
        end
    end

    always_comb begin
        sync1_d  = choose_vga_mode;
        sync2_d  = sync1_q;
        h_last   = (hcount_q == htot - 11'd1);
        v_last   = (vcount_q == vtot - 10'd1);
        hcount_d = h_last ? 11'd0 : hcount_q + 11'd1;
        vcount_d = vcount_q;
        if (h_last) begin
            vcount_d = v_last ? 10'd0 : vcount_q + 10'd1;
        end
        mode_d = (h_last && v_last) ? sync2_q : mode_q;
    end

    // Bar index counts how many of the seven bar edges the pixel has passed.
    always_comb begin
        bar = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (hcount_q >= (mode_q ? 11'(k * H1_BW) : 11'(k * H0_BW))) begin
                bar = bar + 3'd1;
            end
        end
    end

    always_comb begin
        active    = (hcount_q < hact) && (vcount_q < vact);
        h_sync_on = (hcount_q >= hss) && (hcount_q < hse);
        v_sync_on = (vcount_q >= vss) && (vcount_q < vse);
        red_d     = 3'd0;
        green_d   = 3'd0;
        blue_d    = 3'd0;
        if (active) begin
            red_d   = {3{bar[2]}};
            green_d = {3{bar[1]}};
            blue_d  = {3{bar[0]}};
`ifdef VGA_BORDER_EN
            if ((hcount_q == 11'd0) || (hcount_q == hact - 11'd1) ||
                (vcount_q == 10'd0) || (vcount_q == vact - 10'd1)) begin
                red_d   = 3'd7;
                green_d = 3'd7;
                blue_d  = 3'd7;
            end
`endif
        end
        // Mode 0 syncs are active-low, mode 1 syncs active-high.
        hs_d = mode_q ? h_sync_on : ~h_sync_on;
        vs_d = mode_q ? v_sync_on : ~v_sync_on;
    end

    always_ff @(posedge CLOCK_25 or negedge reset) begin
        if (!reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            mode_q   <= 1'b0;
            hcount_q <= 11'd0;
            vcount_q <= 10'd0;
            red_q    <= 3'd0;
            green_q  <= 3'd0;
            blue_q   <= 3'd0;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            mode_q   <= mode_d;
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            red_q    <= red_d;
            green_q  <= green_d;
            blue_q   <= blue_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
        end
    end

    assign VGA_RED   = red_q;
    assign VGA_GREEN = green_q;
    assign VGA_BLUE  = blue_q;
    assign HS        = hs_q;
    assign VS        = vs_q;

endmodule

// File: tb/tb_vga_resolution_demonstrator.sv
// Bench for vga_resolution_demonstrator: a shrunken-geometry instance for whole-frame and mode
// switching scenarios, plus a default-geometry instance for full-size line checks.
module tb_vga_resolution_demonstrator;

    localparam int SH0A = 64, SH0F = 4, SH0S = 8, SH0B = 4;
    localparam int SV0A = 8,  SV0F = 2, SV0S = 2, SV0B = 3;
    localparam int SH1A = 80, SH1F = 6, SH1S = 6, SH1B = 8;
    localparam int SV1A = 10, SV1F = 1, SV1S = 2, SV1B = 3;
    localparam int S0_HTOT = SH0A + SH0F + SH0S + SH0B;
    localparam int S1_HTOT = SH1A + SH1F + SH1S + SH1B;
    localparam int S0_TOT  = S0_HTOT * (SV0A + SV0F + SV0S + SV0B);
    localparam int S1_TOT  = S1_HTOT * (SV1A + SV1F + SV1S + SV1B);
    localparam logic [10:0] RST_VAL = {9'd0, 1'b1, 1'b1};
`ifdef VGA_BORDER_EN
    localparam logic [8:0] COL0 = 9'o777;
`else
    localparam logic [8:0] COL0 = 9'o000;
`endif

    logic clk = 1'b0;
    logic reset;
    logic choose_s;
    logic choose_f;
    logic [2:0] red_s, green_s, blue_s, red_f, green_f, blue_f;
    logic hs_s, vs_s, hs_f, vs_f;
    logic [10:0] obs_s, obs_f;

    int pass_cnt = 0;
    int check_cnt = 0;

    // Model state and the expected outputs it publishes for the current cycle.
    int m_t_s, m_t_f;
    bit m_mode, m_c1, m_c2;
    logic [10:0] exp_s, exp_f;
    int pub_mode, pub_h_s, pub_v_s, pub_h_f, pub_v_f;

    always #5 clk = ~clk;

    vga_resolution_demonstrator #(
        .H0_ACT(SH0A), .H0_FP(SH0F), .H0_SYNC(SH0S), .H0_BP(SH0B),
        .V0_ACT(SV0A), .V0_FP(SV0F), .V0_SYNC(SV0S), .V0_BP(SV0B),
        .H1_ACT(SH1A), .H1_FP(SH1F), .H1_SYNC(SH1S), .H1_BP(SH1B),
        .V1_ACT(SV1A), .V1_FP(SV1F), .V1_SYNC(SV1S), .V1_BP(SV1B)
    ) dut_s (
        .CLOCK_25(clk), .reset(reset), .choose_vga_mode(choose_s),
        .VGA_RED(red_s), .VGA_GREEN(green_s), .VGA_BLUE(blue_s), .HS(hs_s), .VS(vs_s)
    );

    vga_resolution_demonstrator dut_f (
        .CLOCK_25(clk), .reset(reset), .choose_vga_mode(choose_f),
        .VGA_RED(red_f), .VGA_GREEN(green_f), .VGA_BLUE(blue_f), .HS(hs_f), .VS(vs_f)
    );

    assign obs_s = {red_s, green_s, blue_s, hs_s, vs_s};
    assign obs_f = {red_f, green_f, blue_f, hs_f, vs_f};

    // Pixel t of a frame (raster order) rendered straight from the geometry rules.
    function automatic logic [10:0] pixel(input int ha, hf, hsy, hb, va, vf, vsy, vb,
                                          input bit pos, input int t);
        int htot, h, v, bw;
        logic [8:0] rgb;
        logic hs_a, vs_a;
        htot = ha + hf + hsy + hb;
        h    = t % htot;
        v    = t / htot;
        bw   = ha / 8;
        rgb  = 9'o000;
        if (h < ha && v < va) begin
            case (h / bw)
                0: rgb = 9'o000;
                1: rgb = 9'o007;
                2: rgb = 9'o070;
                3: rgb = 9'o077;
                4: rgb = 9'o700;
                5: rgb = 9'o707;
                6: rgb = 9'o770;
                default: rgb = 9'o777;
            endcase
`ifdef VGA_BORDER_EN
            if (h == 0 || h == ha - 1 || v == 0 || v == va - 1) rgb = 9'o777;
`endif
        end
        hs_a = (h >= ha + hf) && (h < ha + hf + hsy);
        vs_a = (v >= va + vf) && (v < va + vf + vsy);
        return {rgb, pos ? hs_a : !hs_a, pos ? vs_a : !vs_a};
    endfunction

    // Outputs seen in cycle n show the raster position held during cycle n-1.
    always @(negedge clk) begin
        if (!reset) begin
            m_t_s = 0; m_t_f = 0; m_mode = 1'b0; m_c1 = 1'b0; m_c2 = 1'b0;
            exp_s = RST_VAL; exp_f = RST_VAL;
            pub_mode = -1; pub_h_s = -1; pub_v_s = -1; pub_h_f = -1; pub_v_f = -1;
        end else begin
            if (m_mode) begin
                exp_s   = pixel(SH1A, SH1F, SH1S, SH1B, SV1A, SV1F, SV1S, SV1B, 1'b1, m_t_s);
                pub_h_s = m_t_s % S1_HTOT;
                pub_v_s = m_t_s / S1_HTOT;
            end else begin
                exp_s   = pixel(SH0A, SH0F, SH0S, SH0B, SV0A, SV0F, SV0S, SV0B, 1'b0, m_t_s);
                pub_h_s = m_t_s % S0_HTOT;
                pub_v_s = m_t_s / S0_HTOT;
            end
            pub_mode = int'(m_mode);
            exp_f    = pixel(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, m_t_f);
            pub_h_f  = m_t_f % 800;
            pub_v_f  = m_t_f / 800;
            if (m_t_s == (m_mode ? S1_TOT : S0_TOT) - 1) begin
                m_t_s  = 0;
                m_mode = m_c2;
            end else begin
                m_t_s++;
            end
            m_t_f = (m_t_f + 1) % 420000;
            m_c2  = m_c1;
            m_c1  = choose_s;
        end
    end

    task automatic test_reset();
        reset = 1'b1; choose_s = 1'b0; choose_f = 1'b0;
        #1 reset = 1'b0;
        #1;
        check_cnt++;
        if (obs_s !== RST_VAL) $display("FAIL reset_small got=%h exp=%h", obs_s, RST_VAL);
        else pass_cnt++;
        check_cnt++;
        if (obs_f !== RST_VAL) $display("FAIL reset_full got=%h exp=%h", obs_f, RST_VAL);
        else pass_cnt++;
        repeat (3) begin
            @(negedge clk); #1;
            check_cnt++;
            if (obs_s !== RST_VAL || obs_f !== RST_VAL)
                $display("FAIL reset_hold got=%h/%h exp=%h", obs_s, obs_f, RST_VAL);
            else pass_cnt++;
        end
        #1 reset = 1'b1;
    endtask

    task automatic test_full_line();
        int f0 = -1, f1 = -1, r0 = -1;
        bit prev = 1'b1;
        logic [8:0] want;
        for (int n = 0; n < 1700; n++) begin
            @(negedge clk); #1;
            check_cnt++;
            if (obs_s !== exp_s) $display("FAIL line_small n=%0d got=%h exp=%h", n, obs_s, exp_s);
            else pass_cnt++;
            check_cnt++;
            if (obs_f !== exp_f) $display("FAIL line_full n=%0d got=%h exp=%h", n, obs_f, exp_f);
            else pass_cnt++;
            if (pub_v_f == 1 && (pub_h_f == 0 || pub_h_f == 80 || pub_h_f == 400 ||
                                 pub_h_f == 639 || pub_h_f >= 640)) begin
                want = (pub_h_f == 0) ? COL0 : (pub_h_f == 80) ? 9'o007 :
                       (pub_h_f == 400) ? 9'o707 : (pub_h_f == 639) ? 9'o777 : 9'o000;
                check_cnt++;
                if (obs_f[10:2] !== want)
                    $display("FAIL pixel_full h=%0d got=%o exp=%o", pub_h_f, obs_f[10:2], want);
                else pass_cnt++;
            end
            if (prev && !obs_f[1]) begin
                if (f0 < 0) f0 = n; else if (f1 < 0) f1 = n;
            end
            if (!prev && obs_f[1] && f0 >= 0 && r0 < 0) r0 = n;
            prev = obs_f[1];
        end
        check_cnt++;
        if (f1 - f0 != 800) $display("FAIL hs_period_full got=%0d exp=800", f1 - f0);
        else pass_cnt++;
        check_cnt++;
        if (r0 - f0 != 96) $display("FAIL hs_low_full got=%0d exp=96", r0 - f0);
        else pass_cnt++;
    endtask

    task automatic test_mode0_frame();
        int f0 = -1, f1 = -1, r0 = -1;
        bit prev = obs_s[0];
        for (int n = 0; n < 2500; n++) begin
            @(negedge clk); #1;
            check_cnt++;
            if (obs_s !== exp_s) $display("FAIL mode0_small n=%0d got=%h exp=%h", n, obs_s, exp_s);
            else pass_cnt++;
            if (pub_v_s >= SV0A) begin
                check_cnt++;
                if (obs_s[10:2] !== 9'o000) $display("FAIL blank_lines v=%0d got=%o exp=0", pub_v_s, obs_s[10:2]);
                else pass_cnt++;
            end
            if (prev && !obs_s[0]) begin
                if (f0 < 0) f0 = n; else if (f1 < 0) f1 = n;
            end
            if (!prev && obs_s[0] && f0 >= 0 && r0 < 0) r0 = n;
            prev = obs_s[0];
        end
        check_cnt++;
        if (f1 - f0 != S0_TOT) $display("FAIL vs_period_m0 got=%0d exp=%0d", f1 - f0, S0_TOT);
        else pass_cnt++;
        check_cnt++;
        if (r0 - f0 != SV0S * S0_HTOT) $display("FAIL vs_low_m0 got=%0d exp=%0d", r0 - f0, SV0S * S0_HTOT);
        else pass_cnt++;
    endtask

    task automatic test_mode1();
        int hr = -1, hw = -1, vr0 = -1, vr1 = -1, vw = -1, last_f = -1, waited = 0;
        bit prev_h, prev_v, prev_fh;
        logic [2:0] k3;
        logic [8:0] want;
        #1 choose_s = 1'b1;
        prev_fh = obs_s[1];
        while (pub_mode != 1 && waited < 1400) begin
            @(negedge clk); #1;
            waited++;
            check_cnt++;
            if (obs_s !== exp_s) $display("FAIL switch01 n=%0d got=%h exp=%h", waited, obs_s, exp_s);
            else pass_cnt++;
            if (pub_mode == 0 && prev_fh && !obs_s[1]) begin
                if (last_f >= 0) begin
                    check_cnt++;
                    if (waited - last_f != S0_HTOT) $display("FAIL old_frame_line got=%0d exp=%0d", waited - last_f, S0_HTOT);
                    else pass_cnt++;
                end
                last_f = waited;
            end
            prev_fh = obs_s[1];
        end
        check_cnt++;
        if (pub_mode != 1) $display("FAIL mode1_timeout got=%0d exp=1", pub_mode);
        else pass_cnt++;
        prev_h = obs_s[1]; prev_v = obs_s[0];
        for (int n = 0; n < 3300; n++) begin
            @(negedge clk); #1;
            check_cnt++;
            if (obs_s !== exp_s) $display("FAIL mode1_small n=%0d got=%h exp=%h", n, obs_s, exp_s);
            else pass_cnt++;
            if (pub_v_s == 1 && pub_h_s >= 10 && pub_h_s < SH1A && pub_h_s % 10 == 0) begin
                k3   = 3'(pub_h_s / 10);
                want = {{3{k3[2]}}, {3{k3[1]}}, {3{k3[0]}}};
                check_cnt++;
                if (obs_s[10:2] !== want) $display("FAIL bar_edge_m1 h=%0d got=%o exp=%o", pub_h_s, obs_s[10:2], want);
                else pass_cnt++;
            end
            if (!prev_h && obs_s[1]) begin
                if (hr >= 0) begin
                    check_cnt++;
                    if (n - hr != S1_HTOT) $display("FAIL hs_period_m1 got=%0d exp=%0d", n - hr, S1_HTOT);
                    else pass_cnt++;
                end
                hr = n;
            end
            if (prev_h && !obs_s[1] && hr >= 0 && hw < 0) hw = n - hr;
            if (!prev_v && obs_s[0]) begin
                if (vr0 < 0) vr0 = n; else if (vr1 < 0) vr1 = n;
            end
            if (prev_v && !obs_s[0] && vr0 >= 0 && vw < 0) vw = n - vr0;
            prev_h = obs_s[1]; prev_v = obs_s[0];
        end
        check_cnt++;
        if (hw != SH1S) $display("FAIL hs_high_m1 got=%0d exp=%0d", hw, SH1S);
        else pass_cnt++;
        check_cnt++;
        if (vr1 - vr0 != S1_TOT) $display("FAIL vs_period_m1 got=%0d exp=%0d", vr1 - vr0, S1_TOT);
        else pass_cnt++;
        check_cnt++;
        if (vw != SV1S * S1_HTOT) $display("FAIL vs_high_m1 got=%0d exp=%0d", vw, SV1S * S1_HTOT);
        else pass_cnt++;
    endtask

    task automatic test_switch_back();
        int delay, waited = 0, f0 = -1, f1 = -1, r0 = -1;
        bit prev;
        delay = $urandom_range(0, 1500);
        for (int n = 0; n < delay; n++) begin
            @(negedge clk); #1;
            check_cnt++;
            if (obs_s !== exp_s) $display("FAIL pre_switch10 n=%0d got=%h exp=%h", n, obs_s, exp_s);
            else pass_cnt++;
        end
        #1 choose_s = 1'b0;
        while (pub_mode != 0 && waited < 1800) begin
            @(negedge clk); #1;
            waited++;
            check_cnt++;
            if (obs_s !== exp_s) $display("FAIL switch10 n=%0d got=%h exp=%h", waited, obs_s, exp_s);
            else pass_cnt++;
        end
        check_cnt++;
        if (pub_mode != 0) $display("FAIL mode0_timeout got=%0d exp=0", pub_mode);
        else pass_cnt++;
        prev = obs_s[1];
        for (int n = 0; n < 250; n++) begin
            @(negedge clk); #1;
            check_cnt++;
            if (obs_s !== exp_s) $display("FAIL back_m0 n=%0d got=%h exp=%h", n, obs_s, exp_s);
            else pass_cnt++;
            if (prev && !obs_s[1]) begin
                if (f0 < 0) f0 = n; else if (f1 < 0) f1 = n;
            end
            if (!prev && obs_s[1] && f0 >= 0 && r0 < 0) r0 = n;
            prev = obs_s[1];
        end
        check_cnt++;
        if (r0 - f0 != SH0S) $display("FAIL hs_low_back got=%0d exp=%0d", r0 - f0, SH0S);
        else pass_cnt++;
        check_cnt++;
        if (f1 - f0 != S0_HTOT) $display("FAIL hs_period_back got=%0d exp=%0d", f1 - f0, S0_HTOT);
        else pass_cnt++;
    endtask

    task automatic test_random_toggles();
        for (int n = 0; n < 6000; n++) begin
            @(negedge clk); #1;
            check_cnt++;
            if (obs_s !== exp_s) $display("FAIL random_small n=%0d got=%h exp=%h", n, obs_s, exp_s);
            else pass_cnt++;
            check_cnt++;
            if (obs_f !== exp_f) $display("FAIL random_full n=%0d got=%h exp=%h", n, obs_f, exp_f);
            else pass_cnt++;
            if ($urandom_range(0, 299) == 0) #1 choose_s = ~choose_s;
        end
    endtask

    task automatic test_reset_midline();
        int waited = 0, f0 = -1, r0 = -1, r1 = -1, w1 = -1;
        bit prev;
        #1 choose_s = 1'b1;
        while (!(pub_mode == 1 && pub_h_s == 40) && waited < 4000) begin
            @(negedge clk); #1;
            waited++;
            check_cnt++;
            if (obs_s !== exp_s) $display("FAIL pre_reset n=%0d got=%h exp=%h", waited, obs_s, exp_s);
            else pass_cnt++;
        end
        check_cnt++;
        if (pub_mode != 1) $display("FAIL midline_timeout got=%0d exp=1", pub_mode);
        else pass_cnt++;
        #1 reset = 1'b0;
        #1;
        check_cnt++;
        if (obs_s !== RST_VAL) $display("FAIL async_reset_small got=%h exp=%h", obs_s, RST_VAL);
        else pass_cnt++;
        check_cnt++;
        if (obs_f !== RST_VAL) $display("FAIL async_reset_full got=%h exp=%h", obs_f, RST_VAL);
        else pass_cnt++;
        repeat (2) begin
            @(negedge clk); #1;
            check_cnt++;
            if (obs_s !== RST_VAL) $display("FAIL reset_hold_mid got=%h exp=%h", obs_s, RST_VAL);
            else pass_cnt++;
        end
        #1 reset = 1'b1;
        prev = 1'b1;
        for (int n = 1; n <= 3000; n++) begin
            @(negedge clk); #1;
            check_cnt++;
            if (obs_s !== exp_s) $display("FAIL after_reset n=%0d got=%h exp=%h", n, obs_s, exp_s);
            else pass_cnt++;
            if (prev && !obs_s[1] && f0 < 0) f0 = n;
            if (!prev && obs_s[1] && f0 >= 0 && r0 < 0) r0 = n;
            if (!prev && obs_s[1] && n >= 1250 && r1 < 0) r1 = n;
            if (prev && !obs_s[1] && r1 >= 0 && w1 < 0) w1 = n - r1;
            prev = obs_s[1];
        end
        check_cnt++;
        if (r0 - f0 != SH0S) $display("FAIL restart_m0_hs_low got=%0d exp=%0d", r0 - f0, SH0S);
        else pass_cnt++;
        check_cnt++;
        if (w1 != SH1S) $display("FAIL resume_m1_hs_high got=%0d exp=%0d", w1, SH1S);
        else pass_cnt++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired after %0d checks", check_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_line();
        test_mode0_frame();
        test_mode1();
        test_switch_back();
        test_random_toggles();
        test_reset_midline();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
